// File: rtl/fps_lyr_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : fps_lyr_sched_if
// Description : Bundles the run-config handshake, layer status and FPS
//               layer-config handshake of the FPS layer scheduler.
//               master = environment (CCU + FPS), slave = scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface fps_lyr_sched_if #(
  parameter int IDX_WIDTH = 10,
  parameter int NUM_LAYER = 8,
  parameter int CYC_WIDTH = 24
);
  localparam int LY_WIDTH = $clog2(NUM_LAYER);

  // CCU <-> scheduler
  logic                           CCUSCH_CfgVld;
  logic                           SCHCCU_CfgRdy;
  logic [LY_WIDTH:0]              CCUSCH_CfgNumLy;
  logic [IDX_WIDTH-1:0]           CCUSCH_CfgNip0;
  logic [NUM_LAYER*IDX_WIDTH-1:0] CCUSCH_CfgNopTab;
  logic                           CCUSCH_Abort;
  logic [LY_WIDTH-1:0]            SCHCCU_LyIdx;
  logic                           SCHCCU_LyDone;
  logic [CYC_WIDTH-1:0]           SCHCCU_LyCyc;
  logic                           SCHCCU_Done;
  logic                           SCHCCU_Err;

  // scheduler <-> FPS
  logic                           SCHFPS_Rst;
  logic                           SCHFPS_CfgVld;
  logic                           FPSSCH_CfgRdy;
  logic [IDX_WIDTH-1:0]           SCHFPS_CfgNip;
  logic [IDX_WIDTH-1:0]           SCHFPS_CfgNop;

  modport master (
    output CCUSCH_CfgVld, CCUSCH_CfgNumLy, CCUSCH_CfgNip0, CCUSCH_CfgNopTab,
           CCUSCH_Abort, FPSSCH_CfgRdy,
    input  SCHCCU_CfgRdy, SCHCCU_LyIdx, SCHCCU_LyDone, SCHCCU_LyCyc,
           SCHCCU_Done, SCHCCU_Err, SCHFPS_Rst, SCHFPS_CfgVld,
           SCHFPS_CfgNip, SCHFPS_CfgNop
  );

  modport slave (
    input  CCUSCH_CfgVld, CCUSCH_CfgNumLy, CCUSCH_CfgNip0, CCUSCH_CfgNopTab,
           CCUSCH_Abort, FPSSCH_CfgRdy,
    output SCHCCU_CfgRdy, SCHCCU_LyIdx, SCHCCU_LyDone, SCHCCU_LyCyc,
           SCHCCU_Done, SCHCCU_Err, SCHFPS_Rst, SCHFPS_CfgVld,
           SCHFPS_CfgNip, SCHFPS_CfgNop
  );
endinterface
`default_nettype wire

// File: rtl/fps_lyr_sched.sv
`default_nettype none
// ============================================================================
// Module      : fps_lyr_sched
// Description : Sequences a multi-layer farthest-point-sampling run. Checks
//               and latches a run config, resets the FPS, hands it one layer
//               config at a time (Nip of layer k = Nop of layer k-1), times
//               each layer and reports layer/run completion or rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module fps_lyr_sched #(
  parameter int IDX_WIDTH = 10,
  parameter int NUM_LAYER = 8,
  parameter int CYC_WIDTH = 24
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  fps_lyr_sched_if.slave bus
);
  localparam int LY_WIDTH = $clog2(NUM_LAYER);
  localparam logic [CYC_WIDTH-1:0] CYC_MAX = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    CFG  = 3'd2,
    RUN  = 3'd3,
    LYDN = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 abort_q, abort_d;     // RST was entered by an abort
  logic                 busy_q, busy_d;       // at least one RUN cycle elapsed
  logic [LY_WIDTH:0]    num_ly_q, num_ly_d;
  logic [IDX_WIDTH-1:0] nip0_q, nip0_d;
  logic [IDX_WIDTH-1:0] nop_tab_q [NUM_LAYER];
  logic [IDX_WIDTH-1:0] nop_tab_d [NUM_LAYER];
  logic [LY_WIDTH-1:0]  ly_idx_q, ly_idx_d;
  logic [IDX_WIDTH-1:0] nip_q, nip_d;
  logic [IDX_WIDTH-1:0] nop_q, nop_d;
  logic [CYC_WIDTH-1:0] cnt_q, cnt_d;
  logic [CYC_WIDTH-1:0] ly_cyc_q, ly_cyc_d;
  logic                 fps_rst_q, fps_rst_d;
  logic                 fps_vld_q, fps_vld_d;
  logic                 ly_done_q, ly_done_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cfg_legal;

  // Legality of the offered config: layer count in range and every used
  // layer reduces (or keeps) a non-empty point set.
  always_comb begin
    logic [IDX_WIDTH-1:0] nip_k;
    logic [IDX_WIDTH-1:0] nop_k;
    cfg_legal = (bus.CCUSCH_CfgNumLy != '0) &&
                (bus.CCUSCH_CfgNumLy <= (LY_WIDTH+1)'(NUM_LAYER));
    nip_k = bus.CCUSCH_CfgNip0;
    nop_k = '0;
    for (int k = 0; k < NUM_LAYER; k++) begin
      nop_k = bus.CCUSCH_CfgNopTab[k*IDX_WIDTH +: IDX_WIDTH];
      if (k < int'(bus.CCUSCH_CfgNumLy)) begin
        if ((nop_k == '0) || (nop_k > nip_k)) cfg_legal = 1'b0;
      end
      nip_k = nop_k;
    end
  end

  // Next-state and next-output computation for the layer sequencer.
  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    busy_d    = 1'b0;
    num_ly_d  = num_ly_q;
    nip0_d    = nip0_q;
    nop_tab_d = nop_tab_q;
    ly_idx_d  = ly_idx_q;
    nip_d     = nip_q;
    nop_d     = nop_q;
    cnt_d     = cnt_q;
    ly_cyc_d  = ly_cyc_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (bus.CCUSCH_CfgVld) begin
          num_ly_d = bus.CCUSCH_CfgNumLy;
          nip0_d   = bus.CCUSCH_CfgNip0;
          for (int k = 0; k < NUM_LAYER; k++) begin
            nop_tab_d[k] = bus.CCUSCH_CfgNopTab[k*IDX_WIDTH +: IDX_WIDTH];
          end
          if (cfg_legal) state_d = RST;
          else           err_d   = 1'b1;
        end
      end
      RST: begin
        ly_idx_d = '0;
        cnt_d    = '0;
        nip_d    = nip0_q;
        nop_d    = nop_tab_q[0];
        // The Rst pulse of this cycle already covers an abort.
        state_d  = (abort_q || bus.CCUSCH_Abort) ? IDLE : CFG;
      end
      CFG: begin
        if (bus.CCUSCH_Abort) begin
          state_d = RST;
          abort_d = 1'b1;
        end else if (bus.FPSSCH_CfgRdy) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.CCUSCH_Abort) begin
          state_d = RST;
          abort_d = 1'b1;
        end else if (busy_q && bus.FPSSCH_CfgRdy) begin
          // Ready in the first RUN cycle is the stale pre-handshake level.
          state_d  = LYDN;
          ly_cyc_d = cnt_q;
        end else begin
          busy_d = 1'b1;
          if (cnt_q != CYC_MAX) cnt_d = cnt_q + CYC_WIDTH'(1);
        end
      end
      LYDN: begin
        if (bus.CCUSCH_Abort) begin
          state_d = RST;
          abort_d = 1'b1;
        end else if ({1'b0, ly_idx_q} == num_ly_q - (LY_WIDTH+1)'(1)) begin
          state_d = FIN;
        end else begin
          ly_idx_d = ly_idx_q + LY_WIDTH'(1);
          nip_d    = nop_q;
          nop_d    = nop_tab_q[ly_idx_d];
          state_d  = CFG;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fps_rst_d = (state_d == RST);
    fps_vld_d = (state_d == CFG);
    ly_done_d = (state_d == LYDN);
    done_d    = (state_d == FIN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      num_ly_q  <= '0;
      nip0_q    <= '0;
      for (int k = 0; k < NUM_LAYER; k++) nop_tab_q[k] <= '0;
      ly_idx_q  <= '0;
      nip_q     <= '0;
      nop_q     <= '0;
      cnt_q     <= '0;
      ly_cyc_q  <= '0;
      fps_rst_q <= 1'b0;
      fps_vld_q <= 1'b0;
      ly_done_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      num_ly_q  <= num_ly_d;
      nip0_q    <= nip0_d;
      nop_tab_q <= nop_tab_d;
      ly_idx_q  <= ly_idx_d;
      nip_q     <= nip_d;
      nop_q     <= nop_d;
      cnt_q     <= cnt_d;
      ly_cyc_q  <= ly_cyc_d;
      fps_rst_q <= fps_rst_d;
      fps_vld_q <= fps_vld_d;
      ly_done_q <= ly_done_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.SCHCCU_CfgRdy = (state_q == IDLE);
  assign bus.SCHCCU_LyIdx  = ly_idx_q;
  assign bus.SCHCCU_LyDone = ly_done_q;
  assign bus.SCHCCU_LyCyc  = ly_cyc_q;
  assign bus.SCHCCU_Done   = done_q;
  assign bus.SCHCCU_Err    = err_q;
  assign bus.SCHFPS_Rst    = fps_rst_q;
  assign bus.SCHFPS_CfgVld = fps_vld_q;
  assign bus.SCHFPS_CfgNip = nip_q;
  assign bus.SCHFPS_CfgNop = nop_q;
endmodule
`default_nettype wire

// File: tb/tb_fps_lyr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fps_lyr_sched
// Description : Bench for fps_lyr_sched with a behavioural FPS responder and
//               an event-level reference of each run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fps_lyr_sched;
  localparam int IW      = 11;
  localparam int NL      = 8;
  localparam int CW      = 8;
  localparam int CYC_SAT = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fps_lyr_sched_if #(.IDX_WIDTH(IW), .NUM_LAYER(NL), .CYC_WIDTH(CW)) bus ();

  fps_lyr_sched #(.IDX_WIDTH(IW), .NUM_LAYER(NL), .CYC_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // FPS responder: busy for busy_len[layer] cycles after each layer handshake;
  // optionally refuses the first hold_req config cycles after an FPS reset.
  int busy_len [NL];
  int hold_req = 0;
  int fps_busy, fps_ptr, fps_hold;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fps_busy <= 0; fps_ptr <= 0; fps_hold <= 0;
    end else if (bus.SCHFPS_Rst) begin
      fps_busy <= 0; fps_ptr <= 0; fps_hold <= hold_req;
    end else if (bus.SCHFPS_CfgVld && bus.FPSSCH_CfgRdy) begin
      fps_busy <= (fps_ptr < NL) ? busy_len[fps_ptr] : 1;
      fps_ptr  <= fps_ptr + 1;
    end else begin
      if (fps_busy != 0) fps_busy <= fps_busy - 1;
      if (bus.SCHFPS_CfgVld && fps_hold != 0) fps_hold <= fps_hold - 1;
    end
  end
  assign bus.FPSSCH_CfgRdy = (fps_busy == 0) && (fps_hold == 0);

  // Event monitor, sampled on the falling edge.
  longint cyc = 0, ccu_hs_cyc = 0, err_cyc = 0;
  int rst_seen = 0, done_seen = 0, err_seen = 0, vld_cycles = 0;
  longint vld_rise [$];
  int hs_nip [$], hs_nop [$], hs_idx [$], ld_idx [$], ld_cyc [$];
  logic vld_prev = 1'b0;
  logic [IW-1:0] nip_prev = '0, nop_prev = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      if (bus.SCHFPS_Rst) rst_seen++;
      if (bus.SCHCCU_Done) done_seen++;
      if (bus.SCHCCU_Err) begin err_seen++; err_cyc = cyc; end
      if (bus.CCUSCH_CfgVld && bus.SCHCCU_CfgRdy) ccu_hs_cyc = cyc;
      if (bus.SCHFPS_CfgVld) begin
        vld_cycles++;
        if (!vld_prev) vld_rise.push_back(cyc);
        else begin
          chk("nip_stable", bus.SCHFPS_CfgNip, nip_prev);
          chk("nop_stable", bus.SCHFPS_CfgNop, nop_prev);
        end
        if (bus.FPSSCH_CfgRdy) begin
          hs_nip.push_back(int'(bus.SCHFPS_CfgNip));
          hs_nop.push_back(int'(bus.SCHFPS_CfgNop));
          hs_idx.push_back(int'(bus.SCHCCU_LyIdx));
        end
      end
      if (bus.SCHCCU_LyDone) begin
        ld_idx.push_back(int'(bus.SCHCCU_LyIdx));
        ld_cyc.push_back(int'(bus.SCHCCU_LyCyc));
      end
    end
    vld_prev = bus.SCHFPS_CfgVld;
    nip_prev = bus.SCHFPS_CfgNip;
    nop_prev = bus.SCHFPS_CfgNop;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfgrdy"}, bus.SCHCCU_CfgRdy, 1);
    chk({tag, "_fpsrst"}, bus.SCHFPS_Rst, 0);
    chk({tag, "_fpsvld"}, bus.SCHFPS_CfgVld, 0);
    chk({tag, "_lydone"}, bus.SCHCCU_LyDone, 0);
    chk({tag, "_done"},   bus.SCHCCU_Done, 0);
    chk({tag, "_err"},    bus.SCHCCU_Err, 0);
    chk({tag, "_lyidx"},  bus.SCHCCU_LyIdx, 0);
    chk({tag, "_lycyc"},  bus.SCHCCU_LyCyc, 0);
    chk({tag, "_nip"},    bus.SCHFPS_CfgNip, 0);
    chk({tag, "_nop"},    bus.SCHFPS_CfgNop, 0);
  endtask

  task automatic drive_cfg(input int numly, input int nip0, input int nop [NL]);
    bus.CCUSCH_CfgVld   = 1'b1;
    bus.CCUSCH_CfgNumLy = 4'(numly);
    bus.CCUSCH_CfgNip0  = IW'(nip0);
    for (int k = 0; k < NL; k++) bus.CCUSCH_CfgNopTab[k*IW +: IW] = IW'(nop[k]);
  endtask

  task automatic scramble_cfg();
    bus.CCUSCH_CfgVld   = 1'b0;
    bus.CCUSCH_CfgNumLy = 4'($urandom);
    bus.CCUSCH_CfgNip0  = IW'($urandom);
    for (int k = 0; k < NL; k++) bus.CCUSCH_CfgNopTab[k*IW +: IW] = IW'($urandom);
  endtask

  // One run: apply config, optional abort / illegal mid-run config, then
  // compare the observed events with what the layer rules predict.
  task automatic run_case(input int numly, input int nip0, input int nop [NL],
                          input int busy [NL], input int hold, input int abort_ly,
                          input bit inject);
    int b_hs, b_ld, b_rise, r0, d0, e0, v0, n, nip, n_hs, n_ld;
    int exp_nip [NL];
    int junk [NL];
    bit legal;
    legal = (numly >= 1) && (numly <= NL);
    nip = nip0;
    for (int k = 0; k < NL; k++) begin
      exp_nip[k] = 0;
      if (k < numly) begin
        exp_nip[k] = nip;
        if (nop[k] < 1 || nop[k] > nip) legal = 1'b0;
        nip = nop[k];
      end
    end
    busy_len = busy;
    hold_req = hold;
    b_hs = hs_nip.size(); b_ld = ld_idx.size(); b_rise = vld_rise.size();
    r0 = rst_seen; d0 = done_seen; e0 = err_seen; v0 = vld_cycles;

    @(posedge clk); #1;
    drive_cfg(numly, nip0, nop);
    @(posedge clk); #1;
    scramble_cfg();

    if (abort_ly >= 0) begin
      n = 0;
      while (hs_nip.size() < b_hs + abort_ly + 1 && n < 5000) begin
        @(posedge clk); #1; n++;
      end
      chk("abort_reach", hs_nip.size() - b_hs, abort_ly + 1);
      repeat (3) @(posedge clk);
      #1 bus.CCUSCH_Abort = 1'b1;
      @(posedge clk); #1;
      bus.CCUSCH_Abort = 1'b0;
      @(negedge clk);
      chk("abort_rdy_1", bus.SCHCCU_CfgRdy, 0);
      chk("abort_rst_1", bus.SCHFPS_Rst, 1);
      @(negedge clk);
      chk("abort_rdy_2", bus.SCHCCU_CfgRdy, 1);
    end

    if (inject && legal && abort_ly < 0) begin
      repeat (4) @(posedge clk);
      #1;
      if (!bus.SCHCCU_CfgRdy) begin
        for (int k = 0; k < NL; k++) junk[k] = $urandom_range(1, 2047);
        drive_cfg(1, 2047, junk);
        @(posedge clk); #1;
        scramble_cfg();
      end
    end

    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(bus.SCHCCU_CfgRdy && n >= 3) && n < 20000);
    repeat (2) @(posedge clk);
    #1;
    chk("end_idle", bus.SCHCCU_CfgRdy, 1);

    n_hs = hs_nip.size() - b_hs;
    n_ld = ld_idx.size() - b_ld;
    if (!legal) begin
      chk("err_cnt",     err_seen - e0, 1);
      chk("err_latency", err_cyc - ccu_hs_cyc, 1);
      chk("err_no_rst",  rst_seen - r0, 0);
      chk("err_no_cfg",  n_hs, 0);
      chk("err_no_done", done_seen - d0, 0);
    end else begin
      chk("err_cnt",  err_seen - e0, 0);
      chk("rst_cnt",  rst_seen - r0, (abort_ly >= 0) ? 2 : 1);
      chk("done_cnt", done_seen - d0, (abort_ly >= 0) ? 0 : 1);
      chk("cfg_cnt",  n_hs, (abort_ly >= 0) ? abort_ly + 1 : numly);
      chk("lydone_cnt", n_ld, (abort_ly >= 0) ? abort_ly : numly);
      if (vld_rise.size() > b_rise) chk("cfg_latency", vld_rise[b_rise] - ccu_hs_cyc, 2);
      else                          chk("cfg_seen", vld_rise.size() - b_rise, 1);
      for (int k = 0; k < n_hs && k < NL; k++) begin
        chk("cfg_idx", hs_idx[b_hs + k], k);
        chk("cfg_nip", hs_nip[b_hs + k], exp_nip[k]);
        chk("cfg_nop", hs_nop[b_hs + k], nop[k]);
      end
      for (int k = 0; k < n_ld && k < NL; k++) begin
        chk("lydone_idx", ld_idx[b_ld + k], k);
        chk("lydone_cyc", ld_cyc[b_ld + k], (busy[k] > CYC_SAT) ? CYC_SAT : busy[k]);
      end
      if (abort_ly < 0) chk("cfgvld_cycles", vld_cycles - v0, numly + hold);
    end
  endtask

  int t_nop [NL];
  int t_busy [NL];
  int t_numly, t_nip0, t_nip, t_bad, t_abort, d_before;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    bus.CCUSCH_CfgVld    = 1'b0;
    bus.CCUSCH_CfgNumLy  = '0;
    bus.CCUSCH_CfgNip0   = '0;
    bus.CCUSCH_CfgNopTab = '0;
    bus.CCUSCH_Abort     = 1'b0;
    for (int k = 0; k < NL; k++) busy_len[k] = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // Two-layer run, 100 busy cycles per layer
    t_nop  = '{512, 128, 0, 0, 0, 0, 0, 0};
    t_busy = '{100, 100, 1, 1, 1, 1, 1, 1};
    run_case(2, 1024, t_nop, t_busy, 0, -1, 1'b0);
    // Layer 1 grows the point set
    t_nop = '{512, 600, 0, 0, 0, 0, 0, 0};
    run_case(2, 1024, t_nop, t_busy, 0, -1, 1'b0);
    // Layer count out of range
    t_nop = '{512, 256, 128, 64, 32, 16, 8, 4};
    run_case(0, 1024, t_nop, t_busy, 0, -1, 1'b0);
    run_case(9, 1024, t_nop, t_busy, 0, -1, 1'b0);
    // All eight layers
    t_busy = '{3, 4, 5, 6, 7, 8, 9, 10};
    run_case(8, 1024, t_nop, t_busy, 0, -1, 1'b1);
    // FPS refuses the first config for 5 cycles
    run_case(3, 1024, t_nop, t_busy, 5, -1, 1'b0);
    // Abort during layer 1
    t_busy = '{20, 40, 20, 1, 1, 1, 1, 1};
    run_case(3, 1024, t_nop, t_busy, 0, 1, 1'b0);
    // Counter saturation
    t_busy = '{CYC_SAT + 11, 1, 1, 1, 1, 1, 1, 1};
    run_case(1, 1024, t_nop, t_busy, 0, -1, 1'b0);

    // Randomised runs
    for (int r = 0; r < 16; r++) begin
      t_numly = $urandom_range(1, NL);
      if ($urandom_range(0, 9) == 0) t_numly = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(NL + 1, 15);
      t_nip0 = $urandom_range(1, 2047);
      t_nip  = t_nip0;
      for (int k = 0; k < NL; k++) begin
        t_nop[k]  = $urandom_range(1, t_nip);
        t_nip     = t_nop[k];
        t_busy[k] = $urandom_range(1, 30);
      end
      if ($urandom_range(0, 5) == 0) begin
        t_bad = $urandom_range(0, NL - 1);
        t_nip = (t_bad == 0) ? t_nip0 : t_nop[t_bad - 1];
        t_nop[t_bad] = (t_nip < 2047 && $urandom_range(0, 1) == 1) ? t_nip + 1 : 0;
      end
      t_abort = -1;
      if (t_numly >= 2 && t_numly <= NL && $urandom_range(0, 4) == 0) begin
        t_abort = $urandom_range(0, t_numly - 1);
        for (int k = 0; k < NL; k++) t_busy[k] = $urandom_range(10, 30);
      end
      run_case(t_numly, t_nip0, t_nop, t_busy, $urandom_range(0, 3), t_abort,
               1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a run
    t_nop  = '{50, 0, 0, 0, 0, 0, 0, 0};
    t_busy = '{50, 1, 1, 1, 1, 1, 1, 1};
    busy_len = t_busy;
    hold_req = 0;
    d_before = done_seen;
    @(posedge clk); #1;
    drive_cfg(1, 100, t_nop);
    @(posedge clk); #1;
    scramble_cfg();
    repeat (10) @(posedge clk);
    #1;
    chk("midrun_busy", bus.SCHCCU_CfgRdy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("midrun_no_done", done_seen - d_before, 0);
    chk("midrun_idle", bus.SCHCCU_CfgRdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fps_lyr_sched.md
FPS_LYR_SCHED -- requirements
Module: fps_lyr_sched

Interface
REQ-001 SHALL have parameter IDX_WIDTH, default 10, point-index/count width.
REQ-002 SHALL have parameter NUM_LAYER, default 8, maximum layers per run; LY_WIDTH = $clog2(NUM_LAYER).
REQ-003 SHALL have parameter CYC_WIDTH, default 24, per-layer cycle-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-high (asserted = 1).
REQ-006 CCUSCH_CfgVld  in  1  run-config valid.
REQ-007 SCHCCU_CfgRdy  out  1  scheduler idle, config accepted.
REQ-008 CCUSCH_CfgNumLy  in  LY_WIDTH+1  layers to run, 1..NUM_LAYER.
REQ-009 CCUSCH_CfgNip0  in  IDX_WIDTH  input point count of layer 0.
REQ-010 CCUSCH_CfgNopTab  in  NUM_LAYER*IDX_WIDTH  output point count per layer; layer k at [k*IDX_WIDTH +: IDX_WIDTH].
REQ-011 CCUSCH_Abort  in  1  abort current run.
REQ-012 SCHFPS_Rst  out  1  one-cycle FPS reset pulse (clears FPS layer index and counters).
REQ-013 SCHFPS_CfgVld  out  1  FPS layer config valid.
REQ-014 FPSSCH_CfgRdy  in  1  FPS idle/ready; high again when the layer finishes.
REQ-015 SCHFPS_CfgNip / SCHFPS_CfgNop  out  IDX_WIDTH each  current-layer Nip/Nop, stable while SCHFPS_CfgVld.
REQ-016 SCHCCU_LyIdx  out  LY_WIDTH  current layer.
REQ-017 SCHCCU_LyDone  out  1  one-cycle pulse per finished layer.
REQ-018 SCHCCU_LyCyc  out  CYC_WIDTH  cycles of the last finished layer, valid with LyDone, held after.
REQ-019 SCHCCU_Done  out  1  one-cycle pulse, whole run finished.
REQ-020 SCHCCU_Err  out  1  one-cycle pulse, config rejected.

Function
REQ-021 States SHALL be IDLE, RST, CFG, RUN, LYDN, FIN; SCHCCU_CfgRdy = (state==IDLE).
REQ-022 IDLE: on CfgVld&CfgRdy, latch NumLy, Nip0, NopTab; go to RST if config legal, else pulse Err next cycle and stay IDLE.
REQ-023 Legal config: 1<=NumLy<=NUM_LAYER; each used layer k: 1<=Nop[k]<=Nip[k], where Nip[0]=Nip0 and Nip[k]=Nop[k-1].
REQ-024 RST: SCHFPS_Rst=1 for exactly one cycle; LyIdx<=0; next state CFG.
REQ-025 CFG: SCHFPS_CfgVld=1 until FPSSCH_CfgRdy=1 (handshake); Nip/Nop held constant; on handshake go RUN, clear cycle counter.
REQ-026 RUN: cycle counter increments each cycle, saturating at all-ones; leave RUN on the first cycle FPSSCH_CfgRdy=1, never in the cycle immediately after the handshake (busy flag set after 1 cycle of Rdy=0 or after 1 cycle elapsed).
REQ-027 LYDN: LyDone=1 one cycle, LyCyc<=counter; if LyIdx==NumLy-1 go FIN, else LyIdx+1, Nip<=previous Nop, go CFG.
REQ-028 FIN: Done=1 one cycle; go IDLE.
REQ-029 Abort in RST/CFG/RUN/LYDN SHALL go to RST-then-IDLE path: one SCHFPS_Rst pulse, no LyDone/Done, then IDLE; Abort in IDLE/FIN ignored.
REQ-030 Abort and handshake in same CFG cycle: Abort wins.
REQ-031 CfgVld while not IDLE SHALL be ignored (not latched).
REQ-032 Latency: CfgVld handshake to first SCHFPS_CfgVld = 2 cycles.
REQ-033 Outputs SHALL be registered except SCHCCU_CfgRdy.

Reset
REQ-034 On rst_n=1: state IDLE; SCHFPS_Rst, SCHFPS_CfgVld, LyDone, Done, Err = 0; LyIdx, LyCyc, Nip, Nop, counter = 0; reset mid-run returns IDLE without Done.

Verification
REQ-035 NumLy=2, Nip0=1024, Nop={512,128}, FPS model busy 100 cycles/layer -> Rst pulse, CfgVld with (1024,512) then (512,128), two LyDone with LyCyc~=100, one Done.
REQ-036 Nop[1]=600>Nop[0]=512 -> Err pulse, no SCHFPS_Rst, stays IDLE.
REQ-037 NumLy=0 or NumLy=9 -> Err pulse.
REQ-038 FPSSCH_CfgRdy held low 5 cycles during CFG -> CfgVld and Nip/Nop stable until handshake.
REQ-039 Abort asserted mid RUN of layer 1 -> one SCHFPS_Rst pulse, no Done, CfgRdy=1 two cycles later.
REQ-040 FPS busy 2^24+10 cycles -> LyCyc = 0xFFFFFF saturated.
